lpc_stage_sequencer: RTL and testbench
======================================

LPC_STAGE_SEQUENCER -- requirements
Module: lpc_stage_sequencer

Interface
REQ-001 SHALL have parameter NUM_STAGES, default 4, number of chained LPC stages (autocorr, lag window, levinson, az-to-lsp).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 4095, maximum cycles a stage may stay busy (12-bit counter).
REQ-003 SHALL have port clk  input  1  single clock, rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  frame start request, sampled in IDLE only.
REQ-006 SHALL have port abort  input  1  synchronous abort, returns block to IDLE.
REQ-007 SHALL have port testOwn  input  1  test bench requests scratch-memory ownership while IDLE.
REQ-008 SHALL have port stageDone  input  NUM_STAGES  per-stage done pulses.
REQ-009 SHALL have port stageStart  output  NUM_STAGES  one-hot, one-cycle stage start pulses.
REQ-010 SHALL have port memOwner  output  3  scratch-memory / operator mux select: stage index 0..NUM_STAGES-1, 7 = test port.
REQ-011 SHALL have port busy  output  1  high from LAUNCH of stage 0 until DONE.
REQ-012 SHALL have port done  output  1  one-cycle pulse when the last stage completes.
REQ-013 SHALL have port err  output  1  sticky timeout flag.
REQ-014 SHALL have port frameCount  output  16  completed-frame counter.

Function
REQ-015 SHALL implement states IDLE, LAUNCH, WAIT, FINISH, ERROR, all registered.
REQ-016 IDLE: start=1 -> LAUNCH with idx=0, err cleared; start while not IDLE SHALL be ignored.
REQ-017 LAUNCH: stageStart[idx]=1 for exactly this one cycle, memOwner=idx, next state WAIT.
REQ-018 WAIT: stageDone[idx]=1 -> LAUNCH with idx+1, or FINISH if idx==NUM_STAGES-1; stageStart[idx+1] is therefore high in the cycle after the done pulse.
REQ-019 WAIT: stageDone bits for stages other than idx SHALL be ignored.
REQ-020 FINISH: done=1 for one cycle, frameCount increments modulo 2^16 (0xFFFF wraps to 0x0000), next state IDLE.
REQ-021 memOwner SHALL hold idx in LAUNCH/WAIT, hold last value in FINISH, be 7 in IDLE when testOwn=1, else 0.
REQ-022 abort=1 in any state SHALL force IDLE next cycle, clear idx and the timeout counter, and suppress done; abort has priority over stageDone and timeout in the same cycle.
REQ-023 stageDone for the current stage and timeout expiry in the same cycle: done SHALL win (stage advances, no err).

Reset
REQ-024 reset low SHALL asynchronously force IDLE, idx=0, stageStart=0, memOwner=0, busy=0, done=0, err=0, frameCount=0, timeout counter=0.
REQ-025 Reset asserted mid-frame SHALL discard the frame without a done pulse; the first start after release begins at stage 0.

Configuration
REQ-026 With LPC_SEQ_TIMEOUT_EN defined: counter runs in WAIT, cleared on LAUNCH; reaching TIMEOUT_CYCLES without stageDone -> ERROR, err=1, busy=0, memOwner=0; ERROR exits to IDLE on start or abort; err stays set until next start.
REQ-027 Without LPC_SEQ_TIMEOUT_EN: no counter and no ERROR state are built, err is tied 0, WAIT waits indefinitely.

Structure
REQ-028 A shared package SHALL hold the state encoding, the MEM_OWNER_TEST constant (3'd7) and the default NUM_STAGES/TIMEOUT_CYCLES values, reused by the G.729 top-level muxes.
REQ-029 The timeout counter SHALL be one sub-module, lpc_stage_timer (clear, enable, expired), instantiated only under LPC_SEQ_TIMEOUT_EN.

Verification
REQ-030 Normal frame: start at cycle 0, each stage asserts done 10 cycles after its start -> stageStart 0b0001,0b0010,0b0100,0b1000 in order, done once, frameCount=1, busy low after.
REQ-031 Spurious done: stageDone=0b0100 while in stage 1 -> no advance; proper stageDone=0b0010 then advances to stage 2.
REQ-032 Abort in stage 2 together with stageDone[2] -> IDLE next cycle, no done, frameCount unchanged, memOwner=0.
REQ-033 Timeout (macro on, TIMEOUT_CYCLES=16): stage 1 never done -> err=1 after 16 WAIT cycles, busy=0; next start clears err and restarts at stage 0.
REQ-034 frameCount preset to 0xFFFF by running 65535 frames (or forced) -> one more frame gives 0x0000; testOwn=1 in IDLE -> memOwner=7, ignored while busy.
REQ-035 Reset pulse low during WAIT of stage 3 -> all outputs zero immediately, no done pulse, fresh start works.

Source files
------------

// File: rtl/lpc_stage_sequencer_pkg.sv
// Shared definitions for the LPC stage sequencer and the G.729 top-level muxes:
// state encoding, memory-owner test code and default sizing.
package lpc_stage_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LAUNCH = 3'd1,
    ST_WAIT   = 3'd2,
    ST_FINISH = 3'd3,
    ST_ERROR  = 3'd4
  } seq_state_t;

  localparam logic [2:0] MEM_OWNER_TEST     = 3'd7;
  localparam int         DEF_NUM_STAGES     = 4;
  localparam int         DEF_TIMEOUT_CYCLES = 4095;

endpackage

// File: rtl/lpc_stage_sequencer_if.sv
// Control bundle between the frame controller / LPC stages and the sequencer.
// The sequencer uses the slave modport; the driving side uses master.
interface lpc_stage_sequencer_if
  import lpc_stage_sequencer_pkg::*;
#(
  parameter int NUM_STAGES = DEF_NUM_STAGES
);

  logic                  start;
  logic                  abort;
  logic                  testOwn;
  logic [NUM_STAGES-1:0] stageDone;
  logic [NUM_STAGES-1:0] stageStart;
  logic [2:0]            memOwner;
  logic                  busy;
  logic                  done;
  logic                  err;
  logic [15:0]           frameCount;

  modport master (
    output start, abort, testOwn, stageDone,
    input  stageStart, memOwner, busy, done, err, frameCount
  );

  modport slave (
    input  start, abort, testOwn, stageDone,
    output stageStart, memOwner, busy, done, err, frameCount
  );

endinterface

// File: rtl/lpc_stage_timer.sv
// Busy-stage watchdog: counts enabled cycles and flags expiry on the
// TIMEOUT_CYCLES-th consecutive enabled cycle.
module lpc_stage_timer
  import lpc_stage_sequencer_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [11:0] r_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= 12'd0;
    end else if (clear) begin
      r_count <= 12'd0;
    end else if (enable) begin
      r_count <= r_count + 12'd1;
    end
  end

  assign expired = enable && (r_count == 12'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/lpc_stage_sequencer.sv
// Walks the chained LPC stages (autocorr, lag window, levinson, az-to-lsp) once
// per frame. Optional stage watchdog is built when LPC_SEQ_TIMEOUT_EN is defined.
module lpc_stage_sequencer
  import lpc_stage_sequencer_pkg::*;
#(
  parameter int NUM_STAGES     = DEF_NUM_STAGES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input logic                  clk,
  input logic                  reset,
  lpc_stage_sequencer_if.slave bus
);

  seq_state_t            r_state;
  seq_state_t            w_state_next;
  logic [2:0]            r_idx;
  logic [2:0]            w_idx_next;
  logic                  r_err;
  logic                  w_err_next;
  logic [15:0]           r_frame_count;
  logic [NUM_STAGES-1:0] w_onehot;
  logic                  w_cur_done;
  logic                  w_last;
  logic                  w_expired;

  assign w_onehot   = NUM_STAGES'(1) << r_idx;
  assign w_cur_done = |(bus.stageDone & w_onehot);
  assign w_last     = (r_idx == 3'(NUM_STAGES - 1));

`ifdef LPC_SEQ_TIMEOUT_EN
  lpc_stage_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   ((r_state != ST_WAIT) || bus.abort),
    .enable  (r_state == ST_WAIT),
    .expired (w_expired)
  );
`else
  assign w_expired = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= ST_IDLE;
      r_idx         <= 3'd0;
      r_err         <= 1'b0;
      r_frame_count <= 16'd0;
    end else begin
      r_state <= w_state_next;
      r_idx   <= w_idx_next;
      r_err   <= w_err_next;
      if ((r_state == ST_FINISH) && !bus.abort) begin
        r_frame_count <= r_frame_count + 16'd1;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    w_err_next   = r_err;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_state_next = ST_LAUNCH;
          w_idx_next   = 3'd0;
          w_err_next   = 1'b0;
        end
      end
      ST_LAUNCH: w_state_next = ST_WAIT;
      ST_WAIT: begin
        // A completing stage beats a simultaneous watchdog expiry.
        if (w_cur_done) begin
          if (w_last) begin
            w_state_next = ST_FINISH;
          end else begin
            w_state_next = ST_LAUNCH;
            w_idx_next   = r_idx + 3'd1;
          end
        end else if (w_expired) begin
          w_state_next = ST_ERROR;
          w_err_next   = 1'b1;
        end
      end
      ST_FINISH: w_state_next = ST_IDLE;
`ifdef LPC_SEQ_TIMEOUT_EN
      ST_ERROR: begin
        if (bus.start) begin
          w_state_next = ST_IDLE;
          w_err_next   = 1'b0;
        end
      end
`endif
      default: w_state_next = ST_IDLE;
    endcase
    // Abort outranks everything, including a start that would clear err.
    if (bus.abort) begin
      w_state_next = ST_IDLE;
      w_idx_next   = 3'd0;
      w_err_next   = r_err;
    end
  end

  always_comb begin
    bus.memOwner = 3'd0;
    case (r_state)
      ST_IDLE:   bus.memOwner = bus.testOwn ? MEM_OWNER_TEST : 3'd0;
      ST_LAUNCH: bus.memOwner = r_idx;
      ST_WAIT:   bus.memOwner = r_idx;
      ST_FINISH: bus.memOwner = r_idx;
      default:   bus.memOwner = 3'd0;
    endcase
  end

  assign bus.stageStart = (r_state == ST_LAUNCH) ? w_onehot : '0;
  assign bus.busy       = (r_state == ST_LAUNCH) || (r_state == ST_WAIT);
  assign bus.done       = (r_state == ST_FINISH) && !bus.abort;
  assign bus.err        = r_err;
  assign bus.frameCount = r_frame_count;

endmodule

// File: tb/tb_lpc_stage_sequencer.sv
// Scoreboard bench for lpc_stage_sequencer: stimulus queues expected stage-start
// and done events, a negedge monitor pops and compares them.
module tb_lpc_stage_sequencer;

  localparam int NS = 4;
  localparam int D  = 10;

  typedef struct {
    logic       is_done;
    logic [3:0] stage;
    logic [2:0] owner;
  } exp_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   exp_fc;
  exp_t q[$];

  lpc_stage_sequencer_if #(.NUM_STAGES(NS)) bus ();

  lpc_stage_sequencer #(
    .NUM_STAGES     (NS),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic push_start(input int s);
    exp_t e;
    e.is_done = 1'b0;
    e.stage   = 4'(1 << s);
    e.owner   = 3'(s);
    q.push_back(e);
  endtask

  task automatic push_done();
    exp_t e;
    e.is_done = 1'b1;
    e.stage   = 4'd0;
    e.owner   = 3'(NS - 1);
    q.push_back(e);
  endtask

  task automatic do_start();
    push_start(0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  // Called in LAUNCH of stage s; leaves the DUT in LAUNCH of s+1 or FINISH.
  task automatic finish_stage(input int s);
    repeat (D) tick();
    bus.stageDone = 4'(1 << s);
    if (s == NS - 1) push_done();
    else push_start(s + 1);
    tick();
    bus.stageDone = '0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (bus.stageStart !== 4'd0 || bus.done !== 1'b0) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output stageStart=%b done=%b owner=%0d t=%0t",
                 bus.stageStart, bus.done, bus.memOwner, $time);
      end else begin
        e = q.pop_front();
        if ({bus.done, bus.stageStart, bus.memOwner} !== {e.is_done, e.stage, e.owner}) begin
          errors++;
          $display("FAIL event got done=%b start=%b owner=%0d exp done=%b start=%b owner=%0d t=%0t",
                   bus.done, bus.stageStart, bus.memOwner, e.is_done, e.stage, e.owner, $time);
        end
      end
    end
  end

  initial begin
    checks        = 0;
    errors        = 0;
    exp_fc        = 0;
    reset         = 1'b0;
    bus.start     = 1'b0;
    bus.abort     = 1'b0;
    bus.testOwn   = 1'b0;
    bus.stageDone = '0;
    repeat (3) tick();
    chk("rst_stageStart", 32'(bus.stageStart), 0);
    chk("rst_memOwner", 32'(bus.memOwner), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_err", 32'(bus.err), 0);
    chk("rst_frameCount", 32'(bus.frameCount), 0);
    reset = 1'b1;
    tick();

    // Normal frame
    do_start();
    tick();
    chk("normal_busy_wait", 32'(bus.busy), 1);
    repeat (D - 1) tick();
    bus.stageDone = 4'b0001;
    push_start(1);
    tick();
    bus.stageDone = '0;
    for (int s = 1; s < NS; s++) finish_stage(s);
    tick();
    exp_fc++;
    chk("normal_frameCount", 32'(bus.frameCount), 32'(exp_fc));
    chk("normal_busy_after", 32'(bus.busy), 0);

    // Spurious done for another stage
    do_start();
    finish_stage(0);
    tick();
    bus.stageDone = 4'b0100;
    tick();
    bus.stageDone = '0;
    chk("spurious_owner", 32'(bus.memOwner), 1);
    chk("spurious_busy", 32'(bus.busy), 1);
    repeat (3) tick();
    chk("spurious_owner_hold", 32'(bus.memOwner), 1);
    for (int s = 1; s < NS; s++) finish_stage(s);
    tick();
    exp_fc++;
    chk("spurious_frameCount", 32'(bus.frameCount), 32'(exp_fc));

    // Abort in stage 2 together with its done
    do_start();
    finish_stage(0);
    finish_stage(1);
    repeat (3) tick();
    bus.stageDone = 4'b0100;
    bus.abort     = 1'b1;
    tick();
    bus.stageDone = '0;
    bus.abort     = 1'b0;
    chk("abort_owner", 32'(bus.memOwner), 0);
    chk("abort_busy", 32'(bus.busy), 0);
    chk("abort_done", 32'(bus.done), 0);
    repeat (3) tick();
    chk("abort_frameCount", 32'(bus.frameCount), 32'(exp_fc));

    // Test-port ownership
    bus.testOwn = 1'b1;
    tick();
    chk("testown_idle", 32'(bus.memOwner), 7);
    do_start();
    tick();
    chk("testown_busy", 32'(bus.memOwner), 0);
    repeat (D - 1) tick();
    bus.stageDone = 4'b0001;
    push_start(1);
    tick();
    bus.stageDone = '0;
    for (int s = 1; s < NS; s++) finish_stage(s);
    tick();
    exp_fc++;
    chk("testown_after", 32'(bus.memOwner), 7);
    bus.testOwn = 1'b0;
    tick();
    chk("testown_off", 32'(bus.memOwner), 0);

    // Stage 1 stalls
    do_start();
    finish_stage(0);
`ifdef LPC_SEQ_TIMEOUT_EN
    repeat (16) tick();
    chk("to_err_before", 32'(bus.err), 0);
    chk("to_busy_before", 32'(bus.busy), 1);
    tick();
    chk("to_err", 32'(bus.err), 1);
    chk("to_busy", 32'(bus.busy), 0);
    chk("to_owner", 32'(bus.memOwner), 0);
    repeat (3) tick();
    chk("to_err_sticky", 32'(bus.err), 1);
    push_start(0);
    bus.start = 1'b1;
    tick();
    chk("to_err_cleared", 32'(bus.err), 0);
    tick();
    bus.start = 1'b0;
    for (int s = 0; s < NS; s++) finish_stage(s);
`else
    repeat (40) tick();
    chk("noto_err", 32'(bus.err), 0);
    chk("noto_busy", 32'(bus.busy), 1);
    chk("noto_owner", 32'(bus.memOwner), 1);
    for (int s = 1; s < NS; s++) finish_stage(s);
`endif
    tick();
    exp_fc++;
    chk("stall_frameCount", 32'(bus.frameCount), 32'(exp_fc));

    // frameCount wrap
    force dut.r_frame_count = 16'hFFFF;
    tick();
    release dut.r_frame_count;
    tick();
    chk("wrap_preset", 32'(bus.frameCount), 32'hFFFF);
    do_start();
    for (int s = 0; s < NS; s++) finish_stage(s);
    tick();
    chk("wrap_frameCount", 32'(bus.frameCount), 0);

    // Asynchronous reset in WAIT of stage 3
    do_start();
    for (int s = 0; s < NS - 1; s++) finish_stage(s);
    repeat (3) tick();
    reset = 1'b0;
    #1;
    chk("rstmid_stageStart", 32'(bus.stageStart), 0);
    chk("rstmid_owner", 32'(bus.memOwner), 0);
    chk("rstmid_busy", 32'(bus.busy), 0);
    chk("rstmid_frameCount", 32'(bus.frameCount), 0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    do_start();
    for (int s = 0; s < NS; s++) finish_stage(s);
    tick();
    chk("rstmid_fresh_frameCount", 32'(bus.frameCount), 1);

    repeat (5) tick();
    chk("queue_empty", 32'(q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
